// File: rtl/multichannel_level_quantizer.sv
// rtl/multichannel_level_quantizer.sv - binary-search level quantizer over a writable threshold table
// Optional per-channel peak hold is built when PEAK_HOLD_EN is defined.
module multichannel_level_quantizer #(
    parameter int DATA_WIDTH = 15,
    parameter int LEVEL_BITS = 5,
    parameter int CHANNELS   = 2,
    parameter int CH_BITS    = 1,
    parameter int HOLD_COUNT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_pcm,
    input  logic [CH_BITS-1:0]    i_channel,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [LEVEL_BITS-1:0] o_position,
    output logic [CH_BITS-1:0]    o_channel,
    output logic [LEVEL_BITS-1:0] o_peak,
    input  logic                  tbl_we,
    input  logic [LEVEL_BITS-1:0] tbl_addr,
    input  logic [DATA_WIDTH-1:0] tbl_data
);

    localparam int DEPTH = 2 ** LEVEL_BITS;
    localparam int BIT_W = (LEVEL_BITS > 1) ? $clog2(LEVEL_BITS) : 1;

    if (CH_BITS < 1 || CHANNELS < 1 || CHANNELS > (1 << CH_BITS) ||
        HOLD_COUNT < 0 || DATA_WIDTH < LEVEL_BITS) begin : g_bad_params
        $error("multichannel_level_quantizer: inconsistent parameters");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    i_ready_q, i_ready_d;
    logic                    o_valid_q, o_valid_d;
    logic [LEVEL_BITS-1:0]   o_position_q, o_position_d;
    logic [CH_BITS-1:0]      o_channel_q, o_channel_d;
    logic [LEVEL_BITS-1:0]   o_peak_q, o_peak_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CH_BITS-1:0]      ch_q, ch_d;
    logic [LEVEL_BITS-1:0]   r_q, r_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   tbl_q [DEPTH];
    logic [DATA_WIDTH-1:0]   tbl_d [DEPTH];

    logic [LEVEL_BITS-1:0]   trial;
    logic [LEVEL_BITS-1:0]   trial_idx;
    logic [LEVEL_BITS-1:0]   r_step;

`ifdef PEAK_HOLD_EN
    localparam int HOLD_BITS = (HOLD_COUNT > 0) ? $clog2(HOLD_COUNT + 1) : 1;

    logic [LEVEL_BITS-1:0]   peak_q [CHANNELS];
    logic [LEVEL_BITS-1:0]   peak_d [CHANNELS];
    logic [HOLD_BITS-1:0]    hold_q [CHANNELS];
    logic [HOLD_BITS-1:0]    hold_d [CHANNELS];
    logic                    ch_in_range;
`endif

    always_comb begin
        state_d      = state_q;
        i_ready_d    = i_ready_q;
        o_valid_d    = o_valid_q;
        o_position_d = o_position_q;
        o_channel_d  = o_channel_q;
        o_peak_d     = o_peak_q;
        data_d       = data_q;
        ch_d         = ch_q;
        r_d          = r_q;
        bit_d        = bit_q;
        tbl_d        = tbl_q;
`ifdef PEAK_HOLD_EN
        peak_d       = peak_q;
        hold_d       = hold_q;
        ch_in_range  = (int'(ch_q) < CHANNELS);
`endif

        // One binary-search step: keep the trial bit if entry t-1 is still below the sample.
        trial     = r_q | (LEVEL_BITS'(1) << bit_q);
        trial_idx = trial - LEVEL_BITS'(1);
        r_step    = (tbl_q[trial_idx] < data_q) ? trial : r_q;

        case (state_q)
            ST_IDLE: begin
                // The write lands before the search begins reading the table on the next cycle.
                if (tbl_we) begin
                    tbl_d[tbl_addr] = tbl_data;
                end
                if (i_valid) begin
                    data_d    = i_pcm;
                    ch_d      = i_channel;
                    r_d       = '0;
                    bit_d     = BIT_W'(LEVEL_BITS - 1);
                    i_ready_d = 1'b0;
                    state_d   = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                r_d   = r_step;
                bit_d = bit_q - BIT_W'(1);
                if (bit_q == '0) begin
                    state_d      = ST_OUTPUT;
                    o_valid_d    = 1'b1;
                    o_position_d = r_step;
                    o_channel_d  = ch_q;
`ifdef PEAK_HOLD_EN
                    if (ch_in_range) begin
                        if (r_step >= peak_q[ch_q]) begin
                            peak_d[ch_q] = r_step;
                            hold_d[ch_q] = HOLD_BITS'(HOLD_COUNT);
                        end else if (hold_q[ch_q] != '0) begin
                            hold_d[ch_q] = hold_q[ch_q] - HOLD_BITS'(1);
                        end else begin
                            // r < p here, so p-1 is already max(p-1, r).
                            peak_d[ch_q] = peak_q[ch_q] - LEVEL_BITS'(1);
                        end
                        o_peak_d = peak_d[ch_q];
                    end else begin
                        o_peak_d = r_step;
                    end
`else
                    o_peak_d = r_step;
`endif
                end
            end
            ST_OUTPUT: begin
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    i_ready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                o_valid_d = 1'b0;
                i_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            i_ready_q    <= 1'b1;
            o_valid_q    <= 1'b0;
            o_position_q <= '0;
            o_channel_q  <= '0;
            o_peak_q     <= '0;
            data_q       <= '0;
            ch_q         <= '0;
            r_q          <= '0;
            bit_q        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tbl_q[k] <= DATA_WIDTH'(((k + 1) << (DATA_WIDTH - LEVEL_BITS)) - 1);
            end
`ifdef PEAK_HOLD_EN
            for (int c = 0; c < CHANNELS; c++) begin
                peak_q[c] <= '0;
                hold_q[c] <= '0;
            end
`endif
        end else begin
            state_q      <= state_d;
            i_ready_q    <= i_ready_d;
            o_valid_q    <= o_valid_d;
            o_position_q <= o_position_d;
            o_channel_q  <= o_channel_d;
            o_peak_q     <= o_peak_d;
            data_q       <= data_d;
            ch_q         <= ch_d;
            r_q          <= r_d;
            bit_q        <= bit_d;
            tbl_q        <= tbl_d;
`ifdef PEAK_HOLD_EN
            peak_q       <= peak_d;
            hold_q       <= hold_d;
`endif
        end
    end

    assign i_ready    = i_ready_q;
    assign o_valid    = o_valid_q;
    assign o_position = o_position_q;
    assign o_channel  = o_channel_q;
    assign o_peak     = o_peak_q;

endmodule

// File: tb/tb_multichannel_level_quantizer.sv
// tb/tb_multichannel_level_quantizer.sv - directed self-checking bench for multichannel_level_quantizer
module tb_multichannel_level_quantizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        i_ready;
    logic [14:0] i_pcm;
    logic [0:0]  i_channel;
    logic        o_valid;
    logic        o_ready;
    logic [4:0]  o_position;
    logic [0:0]  o_channel;
    logic [4:0]  o_peak;
    logic        tbl_we;
    logic [4:0]  tbl_addr;
    logic [14:0] tbl_data;

    int n_checks = 0;
    int n_fail   = 0;

    multichannel_level_quantizer #(
        .DATA_WIDTH(15), .LEVEL_BITS(5), .CHANNELS(2), .CH_BITS(1), .HOLD_COUNT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_pcm(i_pcm), .i_channel(i_channel),
        .o_valid(o_valid), .o_ready(o_ready), .o_position(o_position),
        .o_channel(o_channel), .o_peak(o_peak),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one sample (optionally with a table write on the same edge) and leave at the negedge after acceptance.
    task automatic accept(input int d, input int ch, input bit we, input int wa, input int wd);
        @(negedge clk);
        check("accept_i_ready", int'(i_ready), 1);
        i_valid   = 1'b1;
        i_pcm     = 15'(d);
        i_channel = 1'(ch);
        tbl_we    = we;
        tbl_addr  = 5'(wa);
        tbl_data  = 15'(wd);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        tbl_we  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int lat0, input int pos, input int ch,
                               input bit chk_pk, input int pk);
        int lat;
        lat = lat0;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_pos"}, int'(o_position), pos);
        check({tag, "_ch"}, int'(o_channel), ch);
`ifdef PEAK_HOLD_EN
        if (chk_pk) check({tag, "_peak"}, int'(o_peak), pk);
`else
        if (chk_pk || !chk_pk) check({tag, "_peak"}, int'(o_peak), pos);
`endif
    endtask

    task automatic release_check(input string tag);
        @(negedge clk);
        check({tag, "_rel_i_ready"}, int'(i_ready), 1);
        check({tag, "_rel_o_valid"}, int'(o_valid), 0);
    endtask

    task automatic sample(input string tag, input int d, input int ch, input int pos,
                          input bit chk_pk, input int pk);
        accept(d, ch, 1'b0, 0, 0);
        wait_result(tag, 0, pos, ch, chk_pk, pk);
        release_check(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_pcm = '0; i_channel = '0;
        o_ready = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_ready", int'(i_ready), 1);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_position", int'(o_position), 0);
        check("rst_o_channel", int'(o_channel), 0);
        check("rst_o_peak", int'(o_peak), 0);
        reset = 1'b0;

        // Default table 1023, 2047, ..., 32767
        sample("d0", 0, 0, 0, 1'b0, 0);
        sample("d1023", 1023, 0, 0, 1'b0, 0);
        sample("d1024", 1024, 0, 1, 1'b0, 0);
        sample("d32767", 32767, 0, 31, 1'b0, 0);

        // Backpressure: result and tag must hold, i_ready stays low, extra samples ignored
        o_ready = 1'b0;
        accept(5000, 0, 1'b0, 0, 0);
        wait_result("bp", 0, 4, 0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_o_valid", int'(o_valid), 1);
            check("bp_pos", int'(o_position), 4);
            check("bp_ch", int'(o_channel), 0);
            check("bp_i_ready", int'(i_ready), 0);
            i_valid   = i[0];
            i_pcm     = 15'd30000;
            i_channel = 1'b1;
        end
        @(negedge clk);
        i_valid = 1'b0;
        o_ready = 1'b1;
        release_check("bp");
        check("bp_pos_after", int'(o_position), 4);

        // Channel tags alternate
        sample("ch0", 20000, 0, 19, 1'b0, 0);
        sample("ch1", 3000, 1, 2, 1'b0, 0);
        sample("ch0b", 20000, 0, 19, 1'b0, 0);

        // Table write on the accept edge is used by that search
        accept(1, 0, 1'b1, 0, 0);
        wait_result("wr_idle", 0, 1, 0, 1'b0, 0);
        release_check("wr_idle");

        // Reset restores the table; a write during SEARCH is dropped
        do_reset();
        accept(1, 0, 1'b0, 0, 0);
        tbl_we = 1'b1; tbl_addr = 5'd0; tbl_data = 15'd0;
        @(negedge clk);
        tbl_we = 1'b0;
        wait_result("wr_search", 1, 0, 0, 1'b0, 0);
        release_check("wr_search");
        sample("wr_dropped", 1, 0, 0, 1'b0, 0);

        // Reset two clocks into SEARCH aborts and restores a modified table
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = 5'd0; tbl_data = 15'd2000;
        @(negedge clk);
        tbl_we = 1'b0;
        sample("mod_tbl", 1024, 0, 0, 1'b0, 0);
        accept(20000, 1, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_i_ready", int'(i_ready), 1);
        check("abort_o_valid", int'(o_valid), 0);
        check("abort_o_position", int'(o_position), 0);
        check("abort_o_channel", int'(o_channel), 0);
        sample("abort_tbl", 1024, 0, 1, 1'b0, 0);

`ifdef PEAK_HOLD_EN
        do_reset();
        sample("pk_ch1", 5000, 1, 4, 1'b1, 4);
        sample("pk_ch0", 21000, 0, 20, 1'b1, 20);
        for (int i = 0; i < 18; i++) begin
            sample("pk_decay", 3000, 0, 2, 1'b1, (i < 16) ? 20 : (i == 16 ? 19 : 18));
        end
        sample("pk_ch1_keep", 3000, 1, 2, 1'b1, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
